// File: rtl/fifo9_gmii_tx_if.sv
// Bundle between the framer and its surroundings: FWFT FIFO read side plus the GMII transmit outputs.
interface fifo9_gmii_tx_if;
  logic [8:0] dout;
  logic       empty;
  logic       rd_en;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic [7:0] gmii_txd;
  logic       frame_done;
  logic       underrun;

  modport master (
    input  dout, empty,
    output rd_en, gmii_tx_en, gmii_tx_er, gmii_txd, frame_done, underrun
  );

  modport slave (
    output dout, empty,
    input  rd_en, gmii_tx_en, gmii_tx_er, gmii_txd, frame_done, underrun
  );
endinterface

// File: rtl/fifo9_gmii_tx.sv
// GMII TX framer fed by a 9-bit FWFT FIFO: preamble/SFD, padding, CRC-32 FCS, IFG and underrun abort.
// GMII outputs are registered; rd_en is combinational and only pops while DATA/DRAIN or a stray terminator sits in IDLE.
module fifo9_gmii_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int ADD_PREAMBLE = 1,
  parameter int ADD_FCS      = 1,
  parameter int PAD_EN       = 1,
  parameter int MIN_LEN      = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic gmii_tx_clk,
  input  logic sys_rst,
  output logic rd_clk,
  fifo9_gmii_tx_if.master io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG,
    S_DRAIN
  } state_t;

  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
  localparam logic [7:0]  IFG_LOAD = 8'(IFG_BYTES - 1);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;
  logic        close_frame;
  logic [10:0] byte_cnt_inc;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] inv;
    logic [7:0]  r;
    inv = ~crc;
    case (idx)
      2'd0:    r = inv[7:0];
      2'd1:    r = inv[15:8];
      2'd2:    r = inv[23:16];
      default: r = inv[31:24];
    endcase
    return r;
  endfunction

  // The counter only feeds the pad decision, so it may stick at its maximum.
  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

  assign io.rd_en = ~sys_rst & ~io.empty &
                    ((state_q == S_DATA) | (state_q == S_DRAIN) |
                     ((state_q == S_IDLE) & ~io.dout[8]));

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    crc_d        = crc_q;
    fcs_idx_d    = fcs_idx_q;
    txd_d        = 8'h00;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    close_frame  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!io.empty && io.dout[8]) begin
          if (ADD_PREAMBLE != 0) begin
            txd_d     = 8'h55;
            tx_en_d   = 1'b1;
            pre_cnt_d = 4'd1;
            state_d   = (PREAMBLE_LEN > 1) ? S_PRE : S_SFD;
          end else begin
            crc_d      = CRC_INIT;
            byte_cnt_d = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_PRE: begin
        txd_d     = 8'h55;
        tx_en_d   = 1'b1;
        pre_cnt_d = pre_cnt_q + 4'd1;
        if (pre_cnt_d == PRE_LAST) state_d = S_SFD;
      end
      S_SFD: begin
        txd_d      = 8'hD5;
        tx_en_d    = 1'b1;
        crc_d      = CRC_INIT;
        byte_cnt_d = '0;
        state_d    = S_DATA;
      end
      S_DATA: begin
        if (io.empty) begin
          txd_d      = 8'h00;
          tx_en_d    = 1'b1;
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = S_DRAIN;
        end else if (io.dout[8]) begin
          txd_d      = io.dout[7:0];
          tx_en_d    = 1'b1;
          crc_d      = crc_byte(crc_q, io.dout[7:0]);
          byte_cnt_d = byte_cnt_inc;
        end else if (PAD_EN != 0 && byte_cnt_q < MIN_CNT) begin
          // Terminator cycle already carries the first pad byte to avoid a bubble.
          txd_d      = 8'h00;
          tx_en_d    = 1'b1;
          crc_d      = crc_byte(crc_q, 8'h00);
          byte_cnt_d = byte_cnt_inc;
          state_d    = S_PAD;
        end else begin
          close_frame = 1'b1;
        end
      end
      S_PAD: begin
        if (byte_cnt_q < MIN_CNT) begin
          txd_d      = 8'h00;
          tx_en_d    = 1'b1;
          crc_d      = crc_byte(crc_q, 8'h00);
          byte_cnt_d = byte_cnt_inc;
        end else begin
          close_frame = 1'b1;
        end
      end
      S_FCS: begin
        txd_d     = fcs_byte(crc_q, fcs_idx_q);
        tx_en_d   = 1'b1;
        fcs_idx_d = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) begin
          frame_done_d = 1'b1;
          state_d      = S_IFG;
        end
      end
      S_IFG: begin
        if (ifg_cnt_q == 8'd0) state_d = S_IDLE;
        else ifg_cnt_d = ifg_cnt_q - 8'd1;
      end
      S_DRAIN: begin
        if (!io.empty && !io.dout[8]) state_d = S_IFG;
      end
      default: state_d = S_IDLE;
    endcase

    if (close_frame) begin
      if (ADD_FCS != 0) begin
        txd_d     = fcs_byte(crc_q, 2'd0);
        tx_en_d   = 1'b1;
        fcs_idx_d = 2'd1;
        state_d   = S_FCS;
      end else begin
        frame_done_d = 1'b1;
        state_d      = S_IFG;
      end
    end

    // Preloaded everywhere else so IFG always starts from a full count.
    if (state_q != S_IFG) ifg_cnt_d = IFG_LOAD;
  end

  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      ifg_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      crc_q        <= CRC_INIT;
      fcs_idx_q    <= '0;
      txd_q        <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      crc_q        <= crc_d;
      fcs_idx_q    <= fcs_idx_d;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign rd_clk        = gmii_tx_clk;
  assign io.gmii_txd   = txd_q;
  assign io.gmii_tx_en = tx_en_q;
  assign io.gmii_tx_er = tx_er_q;
  assign io.frame_done = frame_done_q;
  assign io.underrun   = underrun_q;

endmodule

// File: tb/tb_fifo9_gmii_tx.sv
// Directed bench for fifo9_gmii_tx: three parameterisations share one clock and reset.
module tb_fifo9_gmii_tx;

  typedef struct packed {
    logic       fd;
    logic       ur;
    logic       er;
    logic       en;
    logic [7:0] d;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo9_gmii_tx_if io0 ();
  fifo9_gmii_tx_if io1 ();
  fifo9_gmii_tx_if io2 ();
  logic rclk0, rclk1, rclk2;

  fifo9_gmii_tx u_def (.gmii_tx_clk(clk), .sys_rst(rst), .rd_clk(rclk0), .io(io0));
  fifo9_gmii_tx #(.ADD_PREAMBLE(0), .PAD_EN(0)) u_raw (.gmii_tx_clk(clk), .sys_rst(rst), .rd_clk(rclk1), .io(io1));
  fifo9_gmii_tx #(.IFG_BYTES(3)) u_ifg (.gmii_tx_clk(clk), .sys_rst(rst), .rd_clk(rclk2), .io(io2));

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic [8:0] fq0[$];
  logic [8:0] fq1[$];
  logic [8:0] fq2[$];
  bit pend0, pend1, pend2;
  logic [7:0] pay[$];
  logic [7:0] exp_w[$];
  smp_t cap[$];
  smp_t smp;

  // FWFT FIFO models: rd_en is sampled mid-cycle, pop and head update land just after the edge.
  always @(negedge clk) begin
    pend0 = io0.rd_en;
    pend1 = io1.rd_en;
    pend2 = io2.rd_en;
  end

  initial begin
    io0.dout = '0; io0.empty = 1'b1;
    io1.dout = '0; io1.empty = 1'b1;
    io2.dout = '0; io2.empty = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pend0 && !rst && fq0.size() > 0) void'(fq0.pop_front());
      if (pend1 && !rst && fq1.size() > 0) void'(fq1.pop_front());
      if (pend2 && !rst && fq2.size() > 0) void'(fq2.pop_front());
      io0.dout = (fq0.size() > 0) ? fq0[0] : 9'h000; io0.empty = (fq0.size() == 0);
      io1.dout = (fq1.size() > 0) ? fq1[0] : 9'h000; io1.empty = (fq1.size() == 0);
      io2.dout = (fq2.size() > 0) ? fq2[0] : 9'h000; io2.empty = (fq2.size() == 0);
    end
  end

  always @(negedge clk) begin
    case (sel)
      0:       smp = {io0.frame_done, io0.underrun, io0.gmii_tx_er, io0.gmii_tx_en, io0.gmii_txd};
      1:       smp = {io1.frame_done, io1.underrun, io1.gmii_tx_er, io1.gmii_tx_en, io1.gmii_txd};
      default: smp = {io2.frame_done, io2.underrun, io2.gmii_tx_er, io2.gmii_tx_en, io2.gmii_txd};
    endcase
    cap.push_back(smp);
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  task automatic push_word(input int inst, input logic [8:0] w);
    case (inst)
      0:       fq0.push_back(w);
      1:       fq1.push_back(w);
      default: fq2.push_back(w);
    endcase
  endtask

  task automatic push_pay(input int inst, input bit term);
    foreach (pay[i]) push_word(inst, {1'b1, pay[i]});
    if (term) push_word(inst, 9'h000);
  endtask

  task automatic build_exp(input bit pre, input int min_len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    exp_w.delete();
    if (pre) begin
      for (int i = 0; i < 7; i++) exp_w.push_back(8'h55);
      exp_w.push_back(8'hD5);
    end
    foreach (pay[i]) begin
      exp_w.push_back(pay[i]);
      c = crc_step(c, pay[i]);
    end
    for (int i = pay.size(); i < min_len; i++) begin
      exp_w.push_back(8'h00);
      c = crc_step(c, 8'h00);
    end
    c = ~c;
    exp_w.push_back(c[7:0]);
    exp_w.push_back(c[15:8]);
    exp_w.push_back(c[23:16]);
    exp_w.push_back(c[31:24]);
  endtask

  task automatic find_run(input int from, output int s, output int len);
    s = -1;
    len = 0;
    for (int i = from; i < cap.size(); i++) if (cap[i].en) begin s = i; break; end
    if (s >= 0) while (s + len < cap.size() && cap[s + len].en) len++;
  endtask

  task automatic count_flags(output int nfd, output int lfd, output int nur, output int lur, output int ner);
    nfd = 0; lfd = -1; nur = 0; lur = -1; ner = 0;
    foreach (cap[i]) begin
      if (cap[i].fd) begin nfd++; lfd = i; end
      if (cap[i].ur) begin nur++; lur = i; end
      if (cap[i].er) ner++;
    end
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    sel = 0;
    push_word(0, 9'h0AB);
    repeat (3) @(negedge clk);
    #1;
    outs = {io0.gmii_tx_en, io0.gmii_tx_er, io0.gmii_txd, io0.frame_done, io0.underrun};
    n_checks++;
    if (outs !== 12'h000) begin n_fail++; $display("FAIL reset_outputs got %03h want 000", outs); end
    n_checks++;
    if (io0.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", io0.rd_en); end
    @(posedge clk);
    #2 rst = 1'b0;
    cap.delete();
    repeat (5) @(negedge clk);
    n_checks++;
    if (fq0.size() != 0) begin n_fail++; $display("FAIL idle_stray_pop fifo words left %0d want 0", fq0.size()); end
    n_checks++;
    if (io0.gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL idle_tx_en got %b want 0", io0.gmii_tx_en); end
  endtask

  task automatic test_frame64();
    int s, len, errs, bad, nfd, lfd, nur, lur, ner;
    logic [7:0] got_b, want_b;
    bit ok;
    sel = 0;
    cap.delete();
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i));
    push_pay(0, 1'b1);
    build_exp(1'b1, 60);
    repeat (110) @(negedge clk);
    find_run(0, s, len);
    n_checks++;
    if (len != 76) begin n_fail++; $display("FAIL f64_tx_en_len got %0d want 76", len); end
    errs = 0; bad = 0; got_b = 'x; want_b = 'x;
    for (int i = 0; i < exp_w.size(); i++)
      if (s < 0 || s + i >= cap.size() || cap[s + i].d !== exp_w[i]) begin
        if (errs == 0) begin bad = i; want_b = exp_w[i]; got_b = (s >= 0 && s + i < cap.size()) ? cap[s + i].d : 8'hxx; end
        errs++;
      end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL f64_bytes %0d wrong, first byte %0d got %02h want %02h", errs, bad, got_b, want_b); end
    count_flags(nfd, lfd, nur, lur, ner);
    n_checks++;
    if (nfd != 1 || lfd != s + len - 1) begin n_fail++; $display("FAIL f64_frame_done count %0d at %0d want 1 at %0d", nfd, lfd, s + len - 1); end
    n_checks++;
    if (nur != 0 || ner != 0) begin n_fail++; $display("FAIL f64_no_error underrun %0d tx_er %0d want 0 0", nur, ner); end
    ok = (s >= 0) && (cap.size() >= s + len + 12);
    if (ok) for (int i = 0; i < 12; i++) if (cap[s + len + i].en) ok = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL f64_ifg_idle got fewer than 12 idle cycles want >=12"); end
  endtask

  task automatic test_crc_raw();
    int s, len, errs, bad, nfd, lfd, nur, lur, ner;
    logic [31:0] fcs_got;
    sel = 1;
    cap.delete();
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_pay(1, 1'b1);
    build_exp(1'b0, 0);
    repeat (40) @(negedge clk);
    find_run(0, s, len);
    n_checks++;
    if (len != 13) begin n_fail++; $display("FAIL raw_tx_en_len got %0d want 13", len); end
    fcs_got = 'x;
    if (s >= 0 && s + 12 < cap.size()) fcs_got = {cap[s + 9].d, cap[s + 10].d, cap[s + 11].d, cap[s + 12].d};
    n_checks++;
    if (fcs_got !== 32'h2639_F4CB) begin n_fail++; $display("FAIL raw_fcs_123456789 got %08h want 2639f4cb", fcs_got); end
    errs = 0; bad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (s < 0 || s + i >= cap.size() || cap[s + i].d !== exp_w[i]) begin if (errs == 0) bad = i; errs++; end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL raw_bytes %0d wrong, first byte %0d want %02h", errs, bad, exp_w[bad]); end
    count_flags(nfd, lfd, nur, lur, ner);
    n_checks++;
    if (nfd != 1) begin n_fail++; $display("FAIL raw_frame_done count %0d want 1", nfd); end
  endtask

  task automatic test_pad();
    int s, len, errs, bad, nfd, lfd, nur, lur, ner;
    sel = 0;
    cap.delete();
    pay.delete();
    for (int i = 0; i < 14; i++) pay.push_back(8'hC0 + 8'(i));
    push_pay(0, 1'b1);
    build_exp(1'b1, 60);
    repeat (110) @(negedge clk);
    find_run(0, s, len);
    n_checks++;
    if (len != 72) begin n_fail++; $display("FAIL pad_tx_en_len got %0d want 72", len); end
    errs = 0; bad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (s < 0 || s + i >= cap.size() || cap[s + i].d !== exp_w[i]) begin if (errs == 0) bad = i; errs++; end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL pad_bytes %0d wrong, first byte %0d want %02h", errs, bad, exp_w[bad]); end
    count_flags(nfd, lfd, nur, lur, ner);
    n_checks++;
    if (nfd != 1 || lfd != s + len - 1) begin n_fail++; $display("FAIL pad_frame_done count %0d at %0d want 1 at %0d", nfd, lfd, s + len - 1); end
  endtask

  task automatic test_underrun();
    int s, len, errs, bad, nfd, lfd, nur, lur, ner, nen;
    sel = 0;
    cap.delete();
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'h40 + 8'(i));
    push_pay(0, 1'b0);
    repeat (50) @(negedge clk);
    find_run(0, s, len);
    n_checks++;
    if (len != 29) begin n_fail++; $display("FAIL ur_tx_en_len got %0d want 29", len); end
    count_flags(nfd, lfd, nur, lur, ner);
    n_checks++;
    if (ner != 1 || s < 0 || !cap[s + len - 1].er || cap[s + len - 1].d !== 8'h00) begin
      n_fail++; $display("FAIL ur_tx_er count %0d want 1 on last byte with txd 00", ner);
    end
    n_checks++;
    if (nur != 1 || lur != s + len - 1) begin n_fail++; $display("FAIL ur_pulse count %0d at %0d want 1 at %0d", nur, lur, s + len - 1); end
    n_checks++;
    if (nfd != 0) begin n_fail++; $display("FAIL ur_no_frame_done got %0d want 0", nfd); end
    cap.delete();
    pay.delete();
    for (int i = 20; i < 100; i++) pay.push_back(8'h40 + 8'(i));
    push_pay(0, 1'b1);
    repeat (100) @(negedge clk);
    nen = 0;
    foreach (cap[i]) if (cap[i].en) nen++;
    n_checks++;
    if (fq0.size() != 0 || nen != 0) begin n_fail++; $display("FAIL ur_drain words left %0d tx_en cycles %0d want 0 0", fq0.size(), nen); end
    cap.delete();
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i) ^ 8'h5A);
    push_pay(0, 1'b1);
    build_exp(1'b1, 60);
    repeat (110) @(negedge clk);
    find_run(0, s, len);
    errs = 0; bad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (s < 0 || s + i >= cap.size() || cap[s + i].d !== exp_w[i]) begin if (errs == 0) bad = i; errs++; end
    n_checks++;
    if (len != 76 || errs != 0) begin n_fail++; $display("FAIL ur_next_frame len %0d wrong bytes %0d want 76 0", len, errs); end
  endtask

  task automatic test_back_to_back();
    int sa, la, sb, lb, errs, bad, nfd, lfd, nur, lur, ner;
    sel = 2;
    cap.delete();
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'(i + 1));
    push_pay(2, 1'b1);
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'hF0 - 8'(i));
    push_pay(2, 1'b1);
    build_exp(1'b1, 60);
    repeat (200) @(negedge clk);
    find_run(0, sa, la);
    find_run((sa < 0) ? 0 : sa + la, sb, lb);
    n_checks++;
    if (la != 72 || lb != 72) begin n_fail++; $display("FAIL b2b_lengths got %0d %0d want 72 72", la, lb); end
    n_checks++;
    if (sb - (sa + la) != 3) begin n_fail++; $display("FAIL b2b_gap got %0d idle cycles want 3", sb - (sa + la)); end
    errs = 0; bad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (sb < 0 || sb + i >= cap.size() || cap[sb + i].d !== exp_w[i]) begin if (errs == 0) bad = i; errs++; end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL b2b_second_bytes %0d wrong, first byte %0d want %02h", errs, bad, exp_w[bad]); end
    count_flags(nfd, lfd, nur, lur, ner);
    n_checks++;
    if (nfd != 2) begin n_fail++; $display("FAIL b2b_frame_done count %0d want 2", nfd); end
  endtask

  task automatic test_reset_mid();
    int s, len, errs, bad, waited;
    logic [12:0] outs;
    sel = 0;
    cap.delete();
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'hA0 + 8'(i));
    push_pay(0, 1'b1);
    waited = 0;
    while (!io0.gmii_tx_en && waited < 40) begin @(negedge clk); waited++; end
    n_checks++;
    if (!io0.gmii_tx_en) begin n_fail++; $display("FAIL rstmid_start tx_en got 0 want 1 within 40 cycles"); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (io0.gmii_tx_en !== 1'b1 || io0.rd_en !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_data tx_en %b rd_en %b want 1 1", io0.gmii_tx_en, io0.rd_en);
    end
    #2 rst = 1'b1;
    #1;
    outs = {io0.gmii_tx_en, io0.gmii_tx_er, io0.gmii_txd, io0.frame_done, io0.underrun, io0.rd_en};
    n_checks++;
    if (outs !== 13'h0000) begin n_fail++; $display("FAIL rstmid_async_clear got %04h want 0000", outs); end
    fq0.delete();
    push_word(0, 9'h033);
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'h80 + 8'(i));
    push_pay(0, 1'b1);
    build_exp(1'b1, 60);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    cap.delete();
    repeat (120) @(negedge clk);
    find_run(0, s, len);
    n_checks++;
    if (fq0.size() != 0 || len != 72) begin n_fail++; $display("FAIL rstmid_next_frame words left %0d len %0d want 0 72", fq0.size(), len); end
    errs = 0; bad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (s < 0 || s + i >= cap.size() || cap[s + i].d !== exp_w[i]) begin if (errs == 0) bad = i; errs++; end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL rstmid_bytes %0d wrong, first byte %0d want %02h", errs, bad, exp_w[bad]); end
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_crc_raw();
    test_pad();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo9_gmii_tx.md
# fifo9_gmii_tx

Parametrised GMII transmit framer: drains frames from a 9-bit first-word-fall-through FIFO and drives a GMII transmitter. It inserts the preamble and SFD, pads short frames, appends the Ethernet FCS, enforces the inter-frame gap and handles FIFO underrun. It replaces the fixed-mode FIFO-to-GMII bridge; every option is selected by parameter, not by `define.

## Interface
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD (1–15); used only when ADD_PREAMBLE=1.
- ADD_PREAMBLE, 1: 1 = emit preamble and SFD (0xD5); 0 = frame starts with the first data byte.
- ADD_FCS, 1: 1 = append a 4-byte CRC-32.
- PAD_EN, 1: 1 = pad frames shorter than MIN_LEN data bytes with 0x00.
- MIN_LEN, 60: minimum data+pad byte count (1–2047).
- IFG_BYTES, 12: idle cycles forced after every frame (1–255).
- gmii_tx_clk  in  1  sole clock; also driven out on rd_clk.
- sys_rst  in  1  asynchronous, active-high reset.
- dout  in  9  FIFO head; [8]=1 data byte of a frame, [8]=0 frame terminator; [7:0] byte.
- empty  in  1  FIFO empty; dout is valid when 0.
- rd_en  out  1  pop FIFO head this cycle (combinational).
- rd_clk  out  1  = gmii_tx_clk.
- gmii_tx_en  out  1  GMII TX_EN (registered).
- gmii_tx_er  out  1  GMII TX_ER (registered).
- gmii_txd  out  8  GMII TXD (registered).
- frame_done  out  1  1-cycle pulse: frame completed without error.
- underrun  out  1  1-cycle pulse: frame aborted because of underrun.

## Operation
- A frame is a run of words with dout[8]=1 followed by one terminator word with dout[8]=0; the terminator is consumed and never transmitted.
- Terminator words seen in IDLE are popped and ignored.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- IDLE
  - When !empty && dout[8] and ADD_PREAMBLE=1: go to PRE, nothing popped.
  - When ADD_PREAMBLE=0: go to DATA.
- PRE: emit 0x55 for PREAMBLE_LEN cycles, then go to SFD. No pops.
- SFD: emit 0xD5, clear CRC to 0xFFFFFFFF and byte_cnt to 0, go to DATA.
  - With ADD_PREAMBLE=0, CRC and byte_cnt are cleared on the IDLE→DATA transition instead.
- DATA, per cycle:
  - !empty && dout[8]: pop, emit the byte, update CRC, byte_cnt+1.
  - !empty && !dout[8]: pop the terminator, then in the same cycle:
    - if PAD_EN && byte_cnt<MIN_LEN: emit 0x00, go to PAD;
    - else if ADD_FCS: emit FCS byte 0, go to FCS;
    - else: tx_en=0, pulse frame_done, go to IFG.
  - empty: underrun handling (below).
- PAD: emit 0x00 (CRC and byte_cnt updated) until byte_cnt reaches MIN_LEN, then FCS or IFG by the same rule. No pops.
- FCS: emit the remaining bytes 1..3 of ~crc, LSB byte first. Pulse frame_done with the last byte, then go to IFG.
- CRC-32: reflected polynomial 0xEDB88320, bytes processed LSB-first; the transmitted FCS byte k is (~crc)[8k+7:8k].
- Underrun (DATA && empty):
  - next cycle emits txd=0x00, tx_en=1, tx_er=1 and pulses underrun;
  - then go to DRAIN. No FCS is sent.
- DRAIN: tx_en=0; rd_en=~empty; discard words until a terminator is popped, then go to IFG.
- IFG: tx_en=0 for exactly IFG_BYTES cycles, then go to IDLE. No pops.
- rd_en = ~empty && (state==DATA || state==DRAIN || (state==IDLE && !dout[8])), forced to 0 while sys_rst=1.
- byte_cnt is 11 bits and saturates at 2047. Padding uses it; transmission of longer frames is unaffected.

## Timing
- Reset (asynchronous, immediate): gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00, frame_done=0, underrun=0, state=IDLE, CRC=0xFFFFFFFF.
  - Reset mid-frame truncates the frame on the wire; the FIFO is not drained.
- Latency from IDLE with a frame at the head:
  - ADD_PREAMBLE=1: first 0x55 on the next edge; first data byte PREAMBLE_LEN+2 cycles later.
  - ADD_PREAMBLE=0: first data byte 2 cycles later.
- No bubbles inside a frame: data → pad → FCS are back-to-back; tx_en stays high continuously from the first preamble byte to the last FCS byte.
- A word popped in cycle n appears on gmii_txd after edge n.
- The next frame's first 0x55 appears no earlier than IFG_BYTES+1 cycles after the last tx_en=1 cycle.
- frame_done and underrun are never asserted in the same cycle.

## Test plan
- Defaults, 64-byte frame 0x00..0x3F:
  - wire: 7×0x55, 0xD5, 64 data bytes, 4 FCS bytes;
  - tx_en high for 76 consecutive cycles; frame_done once; ≥12 idle cycles follow.
- ADD_PREAMBLE=0, PAD_EN=0, frame ASCII "123456789": FCS bytes on the wire are 0x26 0x39 0xF4 0xCB.
- Defaults, 14-byte frame:
  - 46 bytes of 0x00 pad follow the data, then 4 FCS bytes matching the CRC of the 60-byte padded payload;
  - tx_en spans 72 cycles.
- Underrun: empty asserted after byte 20 of a 100-byte frame:
  - one cycle with tx_er=1 and tx_en=1; underrun pulses;
  - the remaining 80 bytes plus terminator are popped with tx_en=0;
  - a following frame is sent correctly after the IFG.
- Back-to-back frames with IFG_BYTES=3: exactly 3 idle cycles between the last FCS byte and the next 0x55.
- sys_rst asserted mid-DATA:
  - outputs go to 0 within the same cycle, without waiting for a clock edge;
  - after release, a stray terminator at the head is popped in IDLE and the next frame transmits normally.
